// File: rtl/seven_seg_pkg.sv
// Shared types, constants and helpers for the seven-segment display path.
// Segment encodings are active-low, bit order {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] digit_idx_t;

    localparam seg_t       SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    localparam seg_t HEX_SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

    // True when this digit and every digit above it are zero; digit 0 always shows.
    function automatic logic is_leading_zero(logic [15:0] value, digit_idx_t digit);
        logic [15:0] upper;
        upper = value >> {digit, 2'b00};
        return (digit != 2'd0) && (upper == 16'h0000);
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational nibble to active-low seven-segment decoder.
// Shared with the LED byte path, so it carries no state.
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX_SEG_TABLE[nibble_i];

endmodule

// File: rtl/seven_seg_scan.sv
// Four-digit common-anode hex display scanner with per-frame snapshot and slot blanking.
// Define SEVEN_SEG_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        p_sync_reset,
    input  logic [15:0] value_i,
    input  logic        enable_i,
    output logic [6:0]  seg_o,
    output logic [3:0]  an_o,
    output logic        frame_tick_o
);

    if (REFRESH_DIV < 2) begin : g_bad_refresh_div
        $error("seven_seg_scan: REFRESH_DIV must be >= 2");
    end
    if (BLANK_CYCLES >= REFRESH_DIV) begin : g_bad_blank_cycles
        $error("seven_seg_scan: BLANK_CYCLES must be < REFRESH_DIV");
    end

    localparam int unsigned      CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       digit_q, digit_d;
    logic [15:0]      shadow_q, shadow_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       an_q, an_d;
    logic             frame_tick_q, frame_tick_d;

    logic             slot_end;
    logic             frame_end;
    logic             show_digit;
    logic [3:0]       cur_nibble;
    logic [6:0]       dec_seg;
    logic [3:0]       an_show;

    hex_to_seg u_hex_to_seg (
        .nibble_i (cur_nibble),
        .seg_o    (dec_seg)
    );

    always_comb begin
        slot_end   = (cnt_q == CNT_LAST);
        frame_end  = slot_end && (digit_q == 2'd3);
        cur_nibble = shadow_q[{digit_q, 2'b00} +: 4];
        an_show    = ~(4'b0001 << digit_q);
        show_digit = (cnt_q >= BLANK_END);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        show_digit = show_digit && !is_leading_zero(shadow_q, digit_q);
`endif
    end

    always_comb begin
        cnt_d        = cnt_q;
        digit_d      = digit_q;
        shadow_d     = shadow_q;
        an_d         = AN_OFF;
        seg_d        = SEG_BLANK;
        frame_tick_d = 1'b0;
        if (!enable_i) begin
            // Track the input while off so re-enable shows the latest value at once.
            cnt_d    = '0;
            digit_d  = 2'd0;
            shadow_d = value_i;
        end else begin
            cnt_d        = slot_end ? '0 : cnt_q + 1'b1;
            digit_d      = slot_end ? digit_q + 2'd1 : digit_q;
            shadow_d     = frame_end ? value_i : shadow_q;
            frame_tick_d = frame_end;
            if (show_digit) begin
                an_d  = an_show;
                seg_d = dec_seg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (p_sync_reset) begin
            cnt_q        <= '0;
            digit_q      <= 2'd0;
            shadow_q     <= 16'h0000;
            an_q         <= AN_OFF;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_q      <= digit_d;
            shadow_q     <= shadow_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg_o        = seg_q;
    assign an_o         = an_q;
    assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench for seven_seg_scan: a timeline model predicts every output cycle.
// Honours SEVEN_SEG_LEADING_ZERO_BLANK_EN when the design is built with it.
module tb_seven_seg_scan;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;
    localparam int          FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        p_sync_reset;
    logic [15:0] value_i;
    logic        enable_i;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;
    logic        frame_tick_o;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       tick;
    } exp_t;

    exp_t        exp_q[$];
    int          m_t      = 0;
    logic [15:0] m_shadow = 16'h0000;
    bit          started  = 0;

    always #5 clk = ~clk;

    seven_seg_scan #(
        .REFRESH_DIV  (DIV),
        .BLANK_CYCLES (BLANK)
    ) dut (
        .clk          (clk),
        .p_sync_reset (p_sync_reset),
        .value_i      (value_i),
        .enable_i     (enable_i),
        .seg_o        (seg_o),
        .an_o         (an_o),
        .frame_tick_o (frame_tick_o)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    // Model: m_t counts enabled cycles since the scan (re)started; slot and digit follow by division.
    always @(posedge clk) begin
        exp_t e;
        int   pos;
        int   d;
        bit   hidden;
        e = '{an: 4'hF, seg: 7'h7F, tick: 1'b0};
        if (p_sync_reset) begin
            m_t      = 0;
            m_shadow = 16'h0000;
        end else if (!enable_i) begin
            m_t      = 0;
            m_shadow = value_i;
        end else begin
            pos    = m_t % DIV;
            d      = (m_t / DIV) % 4;
            hidden = (pos < BLANK);
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (d != 0 && (m_shadow >> (4 * d)) == 16'h0000) hidden = 1;
`endif
            if (!hidden) begin
                e.an  = ~(4'b0001 << d);
                e.seg = ref_seg(m_shadow[4*d +: 4]);
            end
            e.tick = (m_t % FRAME) == FRAME - 1;
            if (e.tick) m_shadow = value_i;
            m_t = (m_t + 1) % FRAME;
        end
        exp_q.push_back(e);
        started = 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty at %0t: got an=%b seg=%b tick=%b, no expectation",
                         $time, an_o, seg_o, frame_tick_o);
            end else begin
                e = exp_q.pop_front();
                if ({an_o, seg_o, frame_tick_o} !== e) begin
                    bad++;
                    $display("FAIL pins at %0t: got an=%b seg=%b tick=%b, want an=%b seg=%b tick=%b",
                             $time, an_o, seg_o, frame_tick_o, e.an, e.seg, e.tick);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance until the scan sits at (digit, cnt); a missed target counts as a failure.
    task automatic wait_slot(input int digit, input int cnt, input string tag);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ((m_t / DIV) % 4 == digit && m_t % DIV == cnt) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_%s: got no scan position, want digit=%0d cnt=%0d", tag, digit, cnt);
        end
    endtask

    task automatic load_show(input logic [15:0] v, input int frames);
        enable_i = 1'b0;
        value_i  = v;
        cyc(2);
        enable_i = 1'b1;
        cyc(frames * FRAME);
    endtask

    initial begin
        int r;
        p_sync_reset = 1'b1;
        enable_i     = 1'b1;
        value_i      = 16'hFFFF;
        cyc(3);
        p_sync_reset = 1'b0;
        value_i      = 16'h1234;
        cyc(3 * FRAME);

        wait_slot(1, 4, "snapshot");
        value_i = 16'hABCD;
        cyc(2 * FRAME + 5);

        wait_slot(0, 4, "disable");
        enable_i = 1'b0;
        cyc(3);
        value_i  = 16'h0008;
        cyc(1);
        enable_i = 1'b1;
        cyc(FRAME);

        wait_slot(2, 5, "reset");
        p_sync_reset = 1'b1;
        cyc(1);
        p_sync_reset = 1'b0;
        cyc(FRAME + 3);

        load_show(16'h0005, 2);
        load_show(16'h0000, 1);
        load_show(16'h1000, 1);
        load_show(16'h3210, 1);
        load_show(16'h7654, 1);
        load_show(16'hBA98, 1);
        load_show(16'hFEDC, 1);
        load_show(16'h0090, 1);

        for (int i = 0; i < 1200; i++) begin
            r = $urandom_range(0, 199);
            if (r < 6) value_i = 16'($urandom);
            if (r == 7) value_i = {12'h000, 4'($urandom)};
            if (r < 2) enable_i = 1'b0;
            else if (r < 30) enable_i = 1'b1;
            p_sync_reset = (r == 199);
            cyc(1);
        end
        p_sync_reset = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
